serial_alu_adder_seq: RTL and testbench



---
 rtl/serial_alu_adder_seq.sv | 117 +++++++++++
 tb/tb_serial_alu_adder_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_adder_seq.sv
// Bit-serial add/subtract sequencer: one full adder cell is reused over WIDTH
// cycles, LSB first, with the carry held in a flip-flop between bits.

module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic z,
  output logic c_out
);
  assign z     = x ^ y ^ c_in;
  assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

module serial_alu_adder_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_z;
  logic             fa_cout;

  full_adder_cell u_cell (
    .x     (opa[0]),
    .y     (opb[0]),
    .c_in  (carry),
    .z     (fa_z),
    .c_out (fa_cout)
  );

  assign sr_next = {fa_z, sr[WIDTH-1:1]};
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (cnt == LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: the inverted operand is captured and the
  // carry flip-flop is preloaded with op.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa      <= '0;
      opb      <= '0;
      sr       <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= op ? ~b : b;
            carry <= op;
            cnt   <= '0;
          end
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          sr    <= sr_next;
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          // The carry register still holds the carry into the MSB here.
          if (cnt == LAST) begin
            result   <= sr_next;
            c_out    <= fa_cout;
            overflow <= carry ^ fa_cout;
            zero     <= (sr_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_adder_seq.sv
// Scoreboard bench for serial_alu_adder_seq: stimulus pushes expected results
// computed with plain arithmetic, a monitor pops them on every done pulse.

module tb_serial_alu_adder_seq;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             op = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;
  logic             zero;

  typedef struct {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    logic             z;
    int               dc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  serial_alu_adder_seq #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act !== req)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    else
      pass_cnt++;
  endtask

  function automatic exp_t refModel(input logic op_i, input logic [WIDTH-1:0] a_i,
                                    input logic [WIDTH-1:0] b_i, input int dc);
    exp_t e;
    logic [WIDTH:0] full;
    if (!op_i) begin
      full = {1'b0, a_i} + {1'b0, b_i};
      e.r  = full[WIDTH-1:0];
      e.c  = full[WIDTH];
      e.v  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (e.r[WIDTH-1] != a_i[WIDTH-1]);
    end else begin
      e.r = a_i - b_i;
      e.c = (a_i >= b_i);
      e.v = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (e.r[WIDTH-1] != a_i[WIDTH-1]);
    end
    e.z  = (e.r == '0);
    e.dc = dc;
    return e;
  endfunction

  // Pulses start for one edge while the DUT is idle; done is due 16 edges later.
  task automatic applyStimulus(input logic op_i, input logic [WIDTH-1:0] a_i,
                               input logic [WIDTH-1:0] b_i, input bit expect_done);
    @(negedge clk);
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    if (expect_done) sb.push_back(refModel(op_i, a_i, b_i, cyc + 1 + WIDTH));
    @(negedge clk);
    start = 1'b0;
    op    = 1'($urandom);
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("completion_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("done_cycle", 32'(cyc), 32'(e.dc));
          checkOutput("result", 32'(result), 32'(e.r));
          checkOutput("c_out", 32'(c_out), 32'(e.c));
          checkOutput("overflow", 32'(overflow), 32'(e.v));
          checkOutput("zero", 32'(zero), 32'(e.z));
        end
      end else if (sb.size() != 0 && cyc > sb[0].dc) begin
        checkOutput("done_missing", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cnt;
    int nxt;
    int pushed;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_result", 32'(result), 0);
    checkOutput("reset_flags", {29'd0, c_out, overflow, zero}, 0);

    applyStimulus(1'b0, 16'h0001, 16'hFFFF, 1'b1);
    waitIdle(40);
    applyStimulus(1'b0, 16'h7FFF, 16'h0001, 1'b1);
    waitIdle(40);
    applyStimulus(1'b1, 16'h0005, 16'h0007, 1'b1);
    waitIdle(40);
    applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b1);
    waitIdle(40);

    // start pulses during RUN and DONE must be ignored; busy lasts 16 cycles.
    applyStimulus(1'b0, 16'h1234, 16'h1111, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_cnt++;
      if (i == 3)  begin start = 1'b1; op = 1'b1; a = 16'hFFFF; b = 16'h0000; end
      if (i == 4)  start = 1'b0;
      if (i == 16) begin start = 1'b1; op = 1'b1; a = 16'h0F0F; b = 16'h00FF; end
      if (i == 17) start = 1'b0;
      @(negedge clk);
    end
    checkOutput("busy_cycles", 32'(busy_cnt), 16);
    waitIdle(40);
    checkOutput("start_in_done_ignored", 32'(busy), 0);

    // Reset in the middle of RUN discards the operation.
    applyStimulus(1'b0, 16'hAAAA, 16'h1111, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrun_rst_busy", 32'(busy), 0);
    checkOutput("midrun_rst_done", 32'(done), 0);
    checkOutput("midrun_rst_result", 32'(result), 0);
    repeat (25) @(negedge clk);
    applyStimulus(1'b1, 16'h0100, 16'h0001, 1'b1);
    waitIdle(40);

    // start held high with operands changing every cycle: accepts every 18 edges.
    @(negedge clk);
    nxt    = cyc + 1;
    pushed = 0;
    while (pushed < 200) begin
      start = 1'b1;
      op    = 1'($urandom);
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) a = b;
      if (cyc + 1 == nxt) begin
        sb.push_back(refModel(op, a, b, nxt + WIDTH));
        nxt = nxt + WIDTH + 2;
        pushed++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    waitIdle(60);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
